snd_arb: RTL and testbench

//  Round-robin send arbiter for the channel FPGA output link. Polls 17 channel FIFOs in turn,

---
 rtl/snd_arb.sv | 122 ++++++++++++
 tb/tb_snd_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_arb.sv
// Round-robin send arbiter: polls NCH channel FIFOs, forwards one header+payload block per grant
// onto a 16-bit 8b/10b link word stream, filling empty slots with idle commas or a trigger K-word.
module snd_arb #(
  parameter int unsigned NCH   = 17,
  parameter logic [15:0] IDLEW = 16'h00BC,
  parameter logic [15:0] TRIGW = 16'h00FC
) (
  input  logic             clk,
  input  logic             reset,
  output logic [NCH-1:0]   arb_want,
  input  logic [NCH-1:0]   fifo_have,
  input  logic [16*NCH-1:0] datain,
  input  logic             trig,
  output logic [4:0]       debug,
  output logic [15:0]      dataout,
  output logic             kchar
);

  typedef enum logic [0:0] {StPoll, StSend} state_e;

  state_e      st_q, st_d;
  logic        gnt_q, gnt_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        miss_q, miss_d;
  logic [8:0]  rem_q, rem_d;
  logic        pend_q, pend_d;
  logic [15:0] dout_q, dout_d;
  logic        kchar_q, kchar_d;

  logic        have;
  logic [15:0] word;
  logic        fwd;
  logic        rel;
  logic        adv;
  logic        serve;

  always_comb begin
    have   = gnt_q & fifo_have[ptr_q];
    word   = datain[{ptr_q, 4'b0000} +: 16];
    st_d   = st_q;
    gnt_d  = 1'b1;
    ptr_d  = ptr_q;
    miss_d = miss_q;
    rem_d  = rem_q;
    fwd    = 1'b0;
    rel    = 1'b0;
    adv    = 1'b0;

    if (gnt_q) begin
      unique case (st_q)
        StPoll: begin
          if (have) begin
            if (word[15]) begin
              fwd   = 1'b1;
              rem_d = word[8:0];
              if (word[8:0] == 9'd0) rel = 1'b1;
              else                   st_d = StSend;
            end else begin
              // Stray payload word with no header: discard and move on.
              rel = 1'b1;
            end
          end else if (miss_q) begin
            adv = 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end
        StSend: begin
          if (have) begin
            fwd   = 1'b1;
            rem_d = rem_q - 9'd1;
            if (rem_q == 9'd1) rel = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (rel || adv) begin
      ptr_d  = (ptr_q == 5'(NCH - 1)) ? 5'd0 : ptr_q + 5'd1;
      st_d   = StPoll;
      miss_d = 1'b0;
    end

    // The read enable is dropped in the very cycle the final word arrives, so the FIFO
    // (one-cycle read latency) is never asked for a word beyond the end of the block.
    arb_want = '0;
    if (gnt_q && !rel) arb_want[ptr_q] = 1'b1;

    serve   = ~fwd & (pend_q | trig);
    pend_d  = serve ? (pend_q & trig) : (pend_q | trig);
    dout_d  = fwd ? word : (serve ? TRIGW : IDLEW);
    kchar_d = ~fwd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= StPoll;
      gnt_q   <= 1'b0;
      ptr_q   <= 5'd0;
      miss_q  <= 1'b0;
      rem_q   <= 9'd0;
      pend_q  <= 1'b0;
      dout_q  <= IDLEW;
      kchar_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      miss_q  <= miss_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      kchar_q <= kchar_d;
    end
  end

  assign debug   = gnt_q ? ptr_q : 5'h1F;
  assign dataout = dout_q;
  assign kchar   = kchar_q;

endmodule

// File: tb/tb_snd_arb.sv
// Bench for snd_arb: FIFO models answer the grant one clock late; link output is logged per cycle
// and compared against block order and timing derived from the arbitration rules.
module tb_snd_arb;
  localparam int NCH = 17;
  localparam logic [15:0] IDLEW = 16'h00BC;
  localparam logic [15:0] TRIGW = 16'h00FC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    arb_want;
  logic [NCH-1:0]    fifo_have = '0;
  logic [16*NCH-1:0] datain = '0;
  logic              trig = 1'b0;
  logic [4:0]        debug;
  logic [15:0]       dataout;
  logic              kchar;

  always #5 clk = ~clk;

  snd_arb dut (
    .clk       (clk),
    .reset     (rst),
    .arb_want  (arb_want),
    .fifo_have (fifo_have),
    .datain    (datain),
    .trig      (trig),
    .debug     (debug),
    .dataout   (dataout),
    .kchar     (kchar)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0]    q [NCH][$];
  logic [NCH-1:0] w_saved;
  logic [15:0]    lg_d[$];
  logic           lg_k[$];
  logic [4:0]     lg_dbg[$];
  logic [NCH-1:0] lg_w[$];
  int             onehot_bad;
  bit             stall_en;

  // One clock: log outputs, let each FIFO answer last cycle's grant, then capture this grant.
  task automatic tick(input bit t, input bit blk);
    @(posedge clk);
    #1;
    lg_d.push_back(dataout);
    lg_k.push_back(kchar);
    lg_dbg.push_back(debug);
    fifo_have = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_saved[i] && !blk && q[i].size() > 0) begin
        if (q[i][0][15] || !stall_en || $urandom_range(3) != 0) begin
          fifo_have[i] = 1'b1;
          datain[16*i +: 16] = q[i].pop_front();
        end
      end
    end
    trig = t;
    @(negedge clk);
    w_saved = arb_want;
    lg_w.push_back(arb_want);
    if ($countones(arb_want) > 1) onehot_bad++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig = 1'b0;
    fifo_have = '0;
    datain = '0;
    w_saved = '0;
    stall_en = 1'b0;
    onehot_bad = 0;
    lg_d.delete(); lg_k.delete(); lg_dbg.delete(); lg_w.delete();
    for (int i = 0; i < NCH; i++) q[i].delete();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (dataout !== IDLEW) begin miscompares++;
      $display("FAIL reset_dataout got %h exp %h", dataout, IDLEW); end
    vectors++; if (kchar !== 1'b1) begin miscompares++;
      $display("FAIL reset_kchar got %b exp 1", kchar); end
    vectors++; if (arb_want !== '0) begin miscompares++;
      $display("FAIL reset_want got %h exp 0", arb_want); end
    vectors++; if (debug !== 5'h1F) begin miscompares++;
      $display("FAIL reset_debug got %h exp 1f", debug); end
  endtask

  task automatic test_poll_walk();
    logic [NCH-1:0] e;
    do_reset();
    release_rst();
    for (int n = 0; n < 40; n++) tick(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      e = '0;
      e[(k / 2) % NCH] = 1'b1;
      vectors++; if (lg_w[k] !== e) begin miscompares++;
        $display("FAIL walk_want k=%0d got %h exp %h", k, lg_w[k], e); end
      vectors++; if (lg_d[k] !== IDLEW || lg_k[k] !== 1'b1) begin miscompares++;
        $display("FAIL walk_idle k=%0d got %h/%b exp %h/1", k, lg_d[k], lg_k[k], IDLEW); end
    end
  endtask

  task automatic test_block();
    logic [15:0] blk[4];
    logic [NCH-1:0] e;
    do_reset();
    blk[0] = 16'h8A03;
    for (int i = 1; i < 4; i++) blk[i] = 16'($urandom) & 16'h7FFF;
    for (int i = 0; i < 4; i++) q[5].push_back(blk[i]);
    release_rst();
    for (int n = 0; n < 20; n++) tick(1'b0, 1'b0);
    vectors++; if (lg_d[11] !== IDLEW) begin miscompares++;
      $display("FAIL block_pre got %h exp %h", lg_d[11], IDLEW); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (lg_d[12+i] !== blk[i] || lg_k[12+i] !== 1'b0) begin miscompares++;
        $display("FAIL block_word%0d got %h/%b exp %h/0", i, lg_d[12+i], lg_k[12+i], blk[i]); end
    end
    vectors++; if (lg_d[16] !== IDLEW || lg_k[16] !== 1'b1) begin miscompares++;
      $display("FAIL block_post got %h/%b exp %h/1", lg_d[16], lg_k[16], IDLEW); end
    e = '0; e[5] = 1'b1;
    vectors++; if (lg_w[13] !== e) begin miscompares++;
      $display("FAIL block_want_mid got %h exp %h", lg_w[13], e); end
    vectors++; if (lg_w[14] !== '0) begin miscompares++;
      $display("FAIL block_want_last got %h exp 0", lg_w[14]); end
    vectors++; if (lg_dbg[15] !== 5'd6) begin miscompares++;
      $display("FAIL block_next_ptr got %0d exp 6", lg_dbg[15]); end
    vectors++; if (q[5].size() != 0) begin miscompares++;
      $display("FAIL block_drained got %0d exp 0", q[5].size()); end
  endtask

  task automatic test_len0();
    do_reset();
    q[0].push_back(16'h8000);
    release_rst();
    for (int n = 0; n < 6; n++) tick(1'b0, 1'b0);
    vectors++; if (lg_w[1] !== '0) begin miscompares++;
      $display("FAIL len0_release got %h exp 0", lg_w[1]); end
    vectors++; if (lg_dbg[1] !== 5'd0) begin miscompares++;
      $display("FAIL len0_dbg_before got %0d exp 0", lg_dbg[1]); end
    vectors++; if (lg_dbg[2] !== 5'd1) begin miscompares++;
      $display("FAIL len0_dbg_after got %0d exp 1", lg_dbg[2]); end
    vectors++; if (lg_d[2] !== 16'h8000 || lg_k[2] !== 1'b0) begin miscompares++;
      $display("FAIL len0_word got %h/%b exp 8000/0", lg_d[2], lg_k[2]); end
    vectors++; if (lg_d[3] !== IDLEW || lg_k[3] !== 1'b1) begin miscompares++;
      $display("FAIL len0_after got %h/%b exp %h/1", lg_d[3], lg_k[3], IDLEW); end
  endtask

  task automatic test_stall();
    logic [15:0] p[3];
    logic [15:0] e[6];
    do_reset();
    for (int i = 0; i < 3; i++) p[i] = 16'($urandom) & 16'h7FFF;
    q[16].push_back(16'hA003);
    for (int i = 0; i < 3; i++) q[16].push_back(p[i]);
    release_rst();
    for (int n = 0; n < 45; n++) tick(1'b0, (n == 35 || n == 36));
    e[0] = 16'hA003; e[1] = p[0]; e[2] = IDLEW; e[3] = IDLEW; e[4] = p[1]; e[5] = p[2];
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (lg_d[34+i] !== e[i] || lg_k[34+i] !== (e[i] == IDLEW)) begin miscompares++;
        $display("FAIL stall_slot%0d got %h/%b exp %h/%b", i, lg_d[34+i], lg_k[34+i], e[i],
                 (e[i] == IDLEW)); end
    end
    vectors++; if (lg_dbg[38] !== 5'd16) begin miscompares++;
      $display("FAIL stall_dbg16 got %0d exp 16", lg_dbg[38]); end
    vectors++; if (lg_dbg[39] !== 5'd0) begin miscompares++;
      $display("FAIL stall_wrap got %0d exp 0", lg_dbg[39]); end
  endtask

  task automatic test_trig_idle();
    do_reset();
    release_rst();
    for (int n = 0; n < 9; n++) tick(n == 3, 1'b0);
    vectors++; if (lg_d[3] !== IDLEW) begin miscompares++;
      $display("FAIL trig_idle_pre got %h exp %h", lg_d[3], IDLEW); end
    vectors++; if (lg_d[4] !== TRIGW || lg_k[4] !== 1'b1) begin miscompares++;
      $display("FAIL trig_idle_word got %h/%b exp %h/1", lg_d[4], lg_k[4], TRIGW); end
    vectors++; if (lg_d[5] !== IDLEW) begin miscompares++;
      $display("FAIL trig_idle_once got %h exp %h", lg_d[5], IDLEW); end
  endtask

  task automatic test_trig_block();
    logic [15:0] blk[7];
    do_reset();
    blk[0] = 16'h8006;
    for (int i = 1; i < 7; i++) blk[i] = 16'($urandom) & 16'h7FFF;
    for (int i = 0; i < 7; i++) q[0].push_back(blk[i]);
    release_rst();
    for (int n = 0; n < 14; n++) tick(n == 3 || n == 5, 1'b0);
    for (int i = 0; i < 7; i++) begin
      vectors++; if (lg_d[2+i] !== blk[i] || lg_k[2+i] !== 1'b0) begin miscompares++;
        $display("FAIL trigblk_word%0d got %h/%b exp %h/0", i, lg_d[2+i], lg_k[2+i], blk[i]); end
    end
    vectors++; if (lg_d[9] !== TRIGW || lg_k[9] !== 1'b1) begin miscompares++;
      $display("FAIL trigblk_after got %h/%b exp %h/1", lg_d[9], lg_k[9], TRIGW); end
    vectors++; if (lg_d[10] !== IDLEW) begin miscompares++;
      $display("FAIL trigblk_single got %h exp %h", lg_d[10], IDLEW); end
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] e;
    do_reset();
    q[0].push_back(16'h8014);
    for (int i = 0; i < 20; i++) q[0].push_back(16'($urandom) & 16'h7FFF);
    release_rst();
    for (int n = 0; n < 6; n++) tick(1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (arb_want !== '0) begin miscompares++;
      $display("FAIL midrst_want got %h exp 0", arb_want); end
    vectors++; if (dataout !== IDLEW || kchar !== 1'b1) begin miscompares++;
      $display("FAIL midrst_link got %h/%b exp %h/1", dataout, kchar, IDLEW); end
    vectors++; if (debug !== 5'h1F) begin miscompares++;
      $display("FAIL midrst_debug got %h exp 1f", debug); end
    do_reset();
    release_rst();
    for (int n = 0; n < 4; n++) tick(1'b0, 1'b0);
    e = '0; e[0] = 1'b1;
    vectors++; if (lg_w[0] !== e || lg_dbg[0] !== 5'd0) begin miscompares++;
      $display("FAIL midrst_restart got %h/%0d exp %h/0", lg_w[0], lg_dbg[0], e); end
    e = '0; e[1] = 1'b1;
    vectors++; if (lg_w[2] !== e) begin miscompares++;
      $display("FAIL midrst_next got %h exp %h", lg_w[2], e); end
  endtask

  // Random blocks loaded up front: each round visits channels in index order and every channel
  // still holding a block sends exactly one, so the expected link stream is known in advance.
  task automatic test_random();
    logic [15:0] exp_q[$];
    int nblk[NCH];
    int ntrig;
    int nfc;
    int badk;
    int n;
    int tail;
    bit empty;
    logic [15:0] h;
    logic [15:0] w;
    do_reset();
    stall_en = 1'b1;
    for (int c = 0; c < NCH; c++) nblk[c] = $urandom_range(2);
    nblk[$urandom_range(NCH - 1)] = 2;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if (r < nblk[c]) begin
          h = 16'h8000 | 16'(c << 9) | 16'($urandom_range(6));
          q[c].push_back(h); exp_q.push_back(h);
          for (int i = 0; i < int'(h[8:0]); i++) begin
            w = 16'($urandom) & 16'h7FFF;
            q[c].push_back(w); exp_q.push_back(w);
          end
        end
      end
    end
    release_rst();
    ntrig = 0; n = 0; tail = 0;
    while (tail < 40 && n < 3000) begin
      empty = 1'b1;
      for (int c = 0; c < NCH; c++) if (q[c].size() != 0) empty = 1'b0;
      if (empty) tail++;
      if (!empty && (n % 37) == 5) ntrig++;
      tick(!empty && (n % 37) == 5, 1'b0);
      n++;
    end
    vectors++; if (tail < 40) begin miscompares++;
      $display("FAIL rand_timeout got %0d cycles exp drain below 3000", n); end
    nfc = 0; badk = 0;
    for (int k = 0; k < lg_d.size(); k++) begin
      if (lg_k[k] === 1'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++;
          $display("FAIL rand_extra k=%0d got %h exp none", k, lg_d[k]);
        end else begin
          w = exp_q.pop_front();
          if (lg_d[k] !== w) begin miscompares++;
            $display("FAIL rand_word k=%0d got %h exp %h", k, lg_d[k], w); end
        end
      end else if (lg_d[k] === TRIGW) nfc++;
      else if (lg_d[k] !== IDLEW) badk++;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++;
      $display("FAIL rand_missing got %0d words left exp 0", exp_q.size()); end
    vectors++; if (nfc != ntrig) begin miscompares++;
      $display("FAIL rand_trig got %0d exp %0d", nfc, ntrig); end
    vectors++; if (badk != 0) begin miscompares++;
      $display("FAIL rand_kword got %0d exp 0", badk); end
    vectors++; if (onehot_bad != 0) begin miscompares++;
      $display("FAIL rand_onehot got %0d exp 0", onehot_bad); end
  endtask

  initial begin
    test_reset();
    test_poll_walk();
    test_block();
    test_len0();
    test_stall();
    test_trig_idle();
    test_trig_block();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
